// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared control-unit state and control-signal types
//
// Purpose : types shared by the SLC-3 control unit and datapath.
//   ctrl_state_t : control FSM state encoding (4 bits, shown on LEDs/hex)
//   ctrl_sig_t   : the eight datapath/SRAM control strobes
//   decode_ctrl  : Moore output decode for a state (+ last-wait-cycle flag)
package lc3b_types;

   typedef enum logic [3:0] {
      HALTED = 4'd0,
      FETCH1 = 4'd1,
      FETCH2 = 4'd2,
      FETCH3 = 4'd3,
      PAUSE  = 4'd4
   } ctrl_state_t;

   typedef struct packed {
      logic load_mar;
      logic load_pc;
      logic load_mdr;
      logic load_ir;
      logic gate_pc;
      logic gate_mdr;
      logic mem_ce;
      logic mem_oe;
   } ctrl_sig_t;

   // last_wait is high on the final SRAM read cycle of FETCH2, the only
   // cycle in which the read data is valid for MDR to capture.
   function automatic ctrl_sig_t decode_ctrl(input ctrl_state_t state,
                                             input logic        last_wait);
      ctrl_sig_t sig;
      sig = '0;
      case (state)
         FETCH1: begin
            sig.gate_pc  = 1'b1;
            sig.load_mar = 1'b1;
            sig.load_pc  = 1'b1;
         end
         FETCH2: begin
            sig.mem_ce   = 1'b1;
            sig.mem_oe   = 1'b1;
            sig.load_mdr = last_wait;
         end
         FETCH3: begin
            sig.gate_mdr = 1'b1;
            sig.load_ir  = 1'b1;
         end
         default: sig = '0;
      endcase
      return sig;
   endfunction

endpackage

// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - SLC-3 instruction fetch sequencer
//
// Purpose : Moore FSM sequencing MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR,
//           then pausing until Continue; Run starts it from HALTED.
// Parameter MEM_WAIT : SRAM read cycles per access (1..15).
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   async active-high, forces HALTED
//   Run       in   debounced level, rising edge starts fetching from HALTED
//   Continue  in   debounced level, rising edge leaves PAUSE
//   load_mar, load_pc, load_mdr, load_ir   out  datapath load strobes
//   gate_pc, gate_mdr                      out  data-bus drivers
//   mem_ce, mem_oe, mem_we                 out  SRAM strobes (active-high)
//   state_dbg[3:0]                         out  current state code
module fetch_control
   import lc3b_types::*;
#(
   parameter int MEM_WAIT = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   output logic       load_mar,
   output logic       load_pc,
   output logic       load_mdr,
   output logic       load_ir,
   output logic       gate_pc,
   output logic       gate_mdr,
   output logic       mem_ce,
   output logic       mem_oe,
   output logic       mem_we,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

   ctrl_state_t r_state;
   logic [3:0]  r_wait;
   logic        r_run_q;
   logic        r_cont_q;

   logic        w_run_rise;
   logic        w_cont_rise;
   logic        w_last_wait;
   ctrl_sig_t   w_sig;

   assign w_run_rise  = Run & ~r_run_q;
   assign w_cont_rise = Continue & ~r_cont_q;
   assign w_last_wait = (r_wait == WAIT_LAST);

   // Edge registers reset to 1 so a button held through reset is not
   // mistaken for a fresh press once reset drops.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state  <= HALTED;
         r_wait   <= 4'd0;
         r_run_q  <= 1'b1;
         r_cont_q <= 1'b1;
      end else begin
         r_run_q  <= Run;
         r_cont_q <= Continue;
         case (r_state)
            HALTED: if (w_run_rise) r_state <= FETCH1;
            FETCH1: begin
               r_state <= FETCH2;
               r_wait  <= 4'd0;
            end
            FETCH2: begin
               if (w_last_wait) begin
                  r_state <= FETCH3;
                  r_wait  <= 4'd0;
               end else begin
                  r_wait  <= r_wait + 4'd1;
               end
            end
            FETCH3: r_state <= PAUSE;
            PAUSE:  if (w_cont_rise) r_state <= FETCH1;
            default: begin
               r_state <= HALTED;
               r_wait  <= 4'd0;
            end
         endcase
      end
   end

   // Outputs decode only the state register and wait counter, so an async
   // reset clears them at once without waiting for a clock edge.
   assign w_sig     = decode_ctrl(r_state, w_last_wait);
   assign load_mar  = w_sig.load_mar;
   assign load_pc   = w_sig.load_pc;
   assign load_mdr  = w_sig.load_mdr;
   assign load_ir   = w_sig.load_ir;
   assign gate_pc   = w_sig.gate_pc;
   assign gate_mdr  = w_sig.gate_mdr;
   assign mem_ce    = w_sig.mem_ce;
   assign mem_oe    = w_sig.mem_oe;
   assign mem_we    = 1'b0;
   assign state_dbg = r_state;

endmodule
